// File: rtl/button_debouncer.sv
// Push-button debouncer: accepts a level change only after STABLE_CYCLES equal samples.
// Optional release strobe btn_rpulse is enabled by defining DEBOUNCE_RELEASE_PULSE_EN.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_synced,
  output logic btn_level,
  output logic btn_pulse
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic btn_rpulse
`endif
);

  localparam int unsigned CNT_WIDTH = $clog2(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 accept_rise, accept_fall;
  logic                 level_next, pulse_next;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic                 rpulse_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      btn_level  <= 1'b0;
      btn_pulse  <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      btn_rpulse <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      btn_level  <= level_next;
      btn_pulse  <= pulse_next;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      btn_rpulse <= rpulse_next;
`endif
    end
  end

  // Any mismatching sample while waiting drops back to idle, so the count restarts from scratch.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      IDLE_LOW: begin
        if (in_synced) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!in_synced) begin
          state_next = IDLE_LOW;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_HIGH;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!in_synced) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (in_synced) begin
          state_next = IDLE_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_LOW;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LOW;
      end
    endcase
  end

  always_comb begin
    accept_rise = (state == WAIT_HIGH) && in_synced  && (cnt == CNT_LAST);
    accept_fall = (state == WAIT_LOW)  && !in_synced && (cnt == CNT_LAST);
    level_next  = btn_level;
    if (accept_rise) begin
      level_next = 1'b1;
    end else if (accept_fall) begin
      level_next = 1'b0;
    end
    pulse_next  = accept_rise;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    rpulse_next = accept_fall;
`endif
  end

endmodule
